// File: rtl/seg7_scan_display.sv
// Eight-digit common-anode seven-segment scanner for the CPU a0 register.
// Shows the captured value as hex, or as unsigned decimal via a sequential double-dabble.
module seg7_scan_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] din,
   input  logic        load,
   input  logic        dec_mode,
   output logic        busy,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  dbg_state
);

   // load is a one-cycle strobe with no ready: a load that arrives while busy is parked
   // in a single pending slot (latest wins) and taken as the converter returns to IDLE.
   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   state_t        state, state_nx;
   logic [CW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [31:0]   disp;
   logic [7:0]    blank;
   logic          dash;
   logic [31:0]   bin_sr;
   logic [39:0]   bcd;
   logic [39:0]   bcd_adj;
   logic [71:0]   shifted;
   logic [4:0]    step;
   logic          pend_valid;
   logic [31:0]   pend_din;
   logic          pend_dec;
   logic          take_valid;
   logic [31:0]   take_din;
   logic          take_dec;
   logic [7:0]    lz_blank;
   logic          lz;
   logic [3:0]    cur_nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_nx   = state;
      take_valid = 1'b0;
      take_din   = din;
      take_dec   = dec_mode;
      case (state)
         IDLE: take_valid = load;
         CONV: if (step == 5'd31) state_nx = DONE;
         DONE: begin
            state_nx = IDLE;
            if (load) begin
               take_valid = 1'b1;
            end else if (pend_valid) begin
               take_valid = 1'b1;
               take_din   = pend_din;
               take_dec   = pend_dec;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (take_valid && take_dec) state_nx = CONV;
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 10; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      shifted = {bcd_adj, bin_sr} << 1;
   end

   // Digit i is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lz       = 1'b1;
      lz_blank = '0;
      for (int i = 7; i >= 1; i--) begin
         lz          = lz & (bcd[4*i +: 4] == 4'd0);
         lz_blank[i] = lz;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         disp       <= '0;
         blank      <= '0;
         dash       <= 1'b0;
         bin_sr     <= '0;
         bcd        <= '0;
         step       <= '0;
         pend_valid <= 1'b0;
         pend_din   <= '0;
         pend_dec   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            CONV: begin
               {bcd, bin_sr} <= shifted;
               step          <= step + 5'd1;
               if (load) begin
                  pend_valid <= 1'b1;
                  pend_din   <= din;
                  pend_dec   <= dec_mode;
               end
            end
            DONE: begin
               pend_valid <= 1'b0;
               if (bcd[39:32] != 8'd0) begin
                  dash  <= 1'b1;
                  blank <= '0;
               end else begin
                  disp  <= bcd[31:0];
                  blank <= lz_blank;
                  dash  <= 1'b0;
               end
            end
            default: ;
         endcase
         // A hex take in DONE overrides the decimal result written just above.
         if (take_valid) begin
            if (take_dec) begin
               bin_sr <= take_din;
               bcd    <= '0;
               step   <= '0;
            end else begin
               disp  <= take_din;
               blank <= '0;
               dash  <= 1'b0;
            end
         end
      end
   end

   assign cur_nib = disp[{idx, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= 8'hFF;
         seg      <= 7'h7F;
      end else begin
         if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + CW'(1);
         end
         if (blank[idx]) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
         end else begin
            an  <= ~(8'b1 << idx);
            seg <= dash ? 7'h3F : hex7(cur_nib);
         end
      end
   end

   assign busy      = (state != IDLE);
   assign dp        = 1'b1;
   assign dbg_state = state;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a timeline-level display model feeds a per-cycle
// expected queue; a separate monitor pops and compares {dp, busy, an, seg}.
module tb_seg7_scan_display;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] din = '0;
   logic        load = 1'b0;
   logic        dec_mode = 1'b0;
   logic        busy;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  dbg_state;

   seg7_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst(rst), .din(din), .load(load), .dec_mode(dec_mode),
      .busy(busy), .an(an), .seg(seg), .dp(dp), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: what the display currently holds and when conversions finish
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0]  f_seg [8];
   logic        f_blank [8];
   logic        conv_on = 1'b0;
   logic [31:0] conv_val;
   int          conv_done;
   logic        pend_on = 1'b0;
   logic [31:0] pend_din;
   logic        pend_dec;
   int          mcyc = 0;
   int          nrst = 0;

   logic [16:0] exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic        drv_done = 1'b0;

   task automatic set_hex(input logic [31:0] v);
      for (int i = 0; i < 8; i++) begin
         f_seg[i]   = hex_tab[v[4*i +: 4]];
         f_blank[i] = 1'b0;
      end
   endtask

   task automatic set_dec(input logic [31:0] v);
      longint val = longint'(v);
      longint p = 1;
      for (int i = 0; i < 8; i++) begin
         if (val >= 100000000) begin
            f_seg[i]   = 7'h3F;
            f_blank[i] = 1'b0;
         end else begin
            f_seg[i]   = hex_tab[int'((val / p) % 10)];
            f_blank[i] = (i > 0) && (val < p);
         end
         p = p * 10;
      end
   endtask

   task automatic do_load(input logic [31:0] d, input logic m);
      if (m) begin
         conv_on   = 1'b1;
         conv_val  = d;
         conv_done = mcyc + 33;
      end else begin
         set_hex(d);
      end
   endtask

   task automatic model_edge(input logic r, input logic l, input logic [31:0] d, input logic m);
      logic [16:0] e;
      logic [7:0]  oh;
      int          di;
      e = '0;
      if (r) begin
         set_hex(32'h0);
         conv_on = 1'b0;
         pend_on = 1'b0;
         nrst    = 0;
         e       = {1'b1, 1'b0, 8'hFF, 7'h7F};
      end else begin
         di = (nrst / SCAN_DIV) % 8;
         oh = 8'b1 << di;
         if (f_blank[di]) e[14:0] = {8'hFF, 7'h7F};
         else             e[14:0] = {~oh, f_seg[di]};
         nrst++;
         if (conv_on && mcyc == conv_done) begin
            set_dec(conv_val);
            conv_on = 1'b0;
            if (l) begin
               pend_on = 1'b1; pend_din = d; pend_dec = m;
            end
            if (pend_on) begin
               pend_on = 1'b0;
               do_load(pend_din, pend_dec);
            end
         end else if (l) begin
            if (conv_on) begin
               pend_on = 1'b1; pend_din = d; pend_dec = m;
            end else begin
               do_load(d, m);
            end
         end
         e[16] = 1'b1;
         e[15] = conv_on;
      end
      mcyc++;
      exp_q.push_back(e);
   endtask

   // driver tasks
   task automatic step(input logic r, input logic l, input logic [31:0] d, input logic m);
      rst = r; load = l; din = d; dec_mode = m;
      model_edge(r, l, d, m);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
   endtask

   // monitor / scoreboard
   initial begin
      logic [16:0] exp_v;
      logic [16:0] act_v;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {dp, busy, an, seg};
            total++;
            if (act_v !== exp_v) begin
               bad++;
               $display("FAIL out_t%0t act dp/busy/an/seg=%b/%b/%h/%h exp=%b/%b/%h/%h",
                        $time, act_v[16], act_v[15], act_v[14:7], act_v[6:0],
                        exp_v[16], exp_v[15], exp_v[14:7], exp_v[6:0]);
            end
         end else if (!drv_done) begin
            total++;
            bad++;
            $display("FAIL underflow_t%0t act=empty exp=entry", $time);
         end
      end
   end

   // stimulus
   initial begin
      logic [31:0] v;
      int          kind;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
      idle(40);
      step(1'b0, 1'b1, 32'h12345678, 1'b0);
      idle(40);
      step(1'b0, 1'b1, 32'd1234, 1'b1);
      idle(75);
      step(1'b0, 1'b1, 32'd100000000, 1'b1);
      idle(70);
      step(1'b0, 1'b1, 32'd0, 1'b1);
      idle(70);
      step(1'b0, 1'b1, 32'd5, 1'b1);
      idle(10);
      step(1'b0, 1'b1, 32'hAB, 1'b0);
      idle(5);
      step(1'b0, 1'b1, 32'd77, 1'b1);
      idle(110);
      step(1'b0, 1'b1, 32'd999, 1'b1);
      idle(10);
      step(1'b1, 1'b0, '0, 1'b0);
      idle(40);
      step(1'b0, 1'b1, 32'd99999999, 1'b1);
      idle(70);
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 19);
         v    = $urandom >> $urandom_range(0, 31);
         if (kind == 0) step(1'b1, 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)));
         else           step(1'b0, 1'b1, v, 1'(kind > 6));
         idle($urandom_range(1, 80));
      end
      idle(70);
      drv_done = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain act=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
